// File: rtl/gate_multi_multi_lamp_pkg.sv
// Shared definitions for the lamp gate: mode encodings, FSM states, fire-counter width.
// Latency: n/a (definitions only); backpressure: none.
package gate_multi_multi_lamp_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_XOR  = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } gate_state_e;

  localparam int FIRE_CNT_W = 16;

endpackage

// File: rtl/gate_multi_multi_lamp_eval.sv
// Combinational popcount-and-mode evaluator; mode_vld is low for the reserved modes 6/7.
// Latency: 0 cycles; backpressure: none.
module gate_lamp_eval
  import gate_multi_multi_lamp_pkg::*;
#(
  parameter int INPUT_COUNT = 2
) (
  input  logic [INPUT_COUNT-1:0] lamp,
  input  logic [2:0]             mode,
  output logic                   eval,
  output logic                   mode_vld
);

  localparam int CNT_W = $clog2(INPUT_COUNT + 1);

  logic [CNT_W-1:0] n_on;

  always_comb begin
    n_on = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      n_on = n_on + CNT_W'(lamp[i]);
    end
  end

  always_comb begin
    eval     = 1'b0;
    mode_vld = 1'b1;
    case (mode)
      GATE_AND:  eval = (n_on == CNT_W'(INPUT_COUNT));
      GATE_OR:   eval = (n_on != '0);
      GATE_XOR:  eval = (n_on == CNT_W'(1));
      GATE_NAND: eval = (n_on != CNT_W'(INPUT_COUNT));
      GATE_NOR:  eval = (n_on == '0);
      GATE_XNOR: eval = (n_on != CNT_W'(1));
      default:   mode_vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_multi_multi_lamp.sv
// Toggle lamps gated into a registered result; out pulses one cycle when the result changes.
// Latency: lamp toggle to out pulse 2 cycles; backpressure: none. Optional GATE_FIRE_COUNT_EN adds fire_count.
module gate_multi_multi_lamp
  import gate_multi_multi_lamp_pkg::*;
#(
  parameter int INPUT_COUNT  = 2,
  parameter int OUTPUT_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    logic_reset,
  input  logic [INPUT_COUNT-1:0]  in,
  input  logic [2:0]              mode,
  output logic [OUTPUT_COUNT-1:0] out,
  output logic [INPUT_COUNT-1:0]  lamp,
  output logic                    result
`ifdef GATE_FIRE_COUNT_EN
  ,
  output logic [FIRE_CNT_W-1:0]   fire_count
`endif
);

  gate_state_e            state_q, state_d;
  logic [INPUT_COUNT-1:0] lamp_q, lamp_d;
  logic                   result_q, result_d;
  logic                   fire_q, fire_d;
  logic                   eval;
  logic                   mode_vld;

  // Evaluation reads the registered lamps, so a toggle reaches result one cycle later.
  gate_lamp_eval #(
    .INPUT_COUNT(INPUT_COUNT)
  ) u_eval (
    .lamp    (lamp_q),
    .mode    (mode),
    .eval    (eval),
    .mode_vld(mode_vld)
  );

  always_comb begin
    lamp_d = lamp_q ^ in;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    fire_d   = 1'b0;
    case (state_q)
      PRIME: begin
        if (mode_vld) begin
          result_d = eval;
        end
        state_d = RUN;
      end
      RUN: begin
        if (mode_vld && (eval != result_q)) begin
          result_d = eval;
          fire_d   = 1'b1;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state_q  <= PRIME;
      lamp_q   <= '0;
      result_q <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lamp_q   <= lamp_d;
      result_q <= result_d;
      fire_q   <= fire_d;
    end
  end

  assign out    = {OUTPUT_COUNT{fire_q}};
  assign lamp   = lamp_q;
  assign result = result_q;

`ifdef GATE_FIRE_COUNT_EN
  logic [FIRE_CNT_W-1:0] fire_cnt_q, fire_cnt_d;

  // Counts on the same edge that raises out; sticks at all-ones.
  always_comb begin
    fire_cnt_d = fire_cnt_q;
    if (fire_d && (fire_cnt_q != '1)) begin
      fire_cnt_d = fire_cnt_q + FIRE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      fire_cnt_q <= '0;
    end else begin
      fire_cnt_q <= fire_cnt_d;
    end
  end

  assign fire_count = fire_cnt_q;
`endif

endmodule

// File: tb/tb_gate_multi_multi_lamp.sv
// Directed vector bench for gate_multi_multi_lamp (INPUT_COUNT=2, OUTPUT_COUNT=2).
// Fire-counter saturation is checked when GATE_FIRE_COUNT_EN is defined.
module tb_gate_multi_multi_lamp;

  logic       clk;
  logic       logic_reset;
  logic [1:0] tb_in;
  logic [2:0] mode;
  logic [1:0] out;
  logic [1:0] lamp;
  logic       result;
`ifdef GATE_FIRE_COUNT_EN
  logic [15:0] fire_count;
`endif

  int checks;
  int errors;

  gate_multi_multi_lamp #(
    .INPUT_COUNT (2),
    .OUTPUT_COUNT(2)
  ) dut (
    .clk        (clk),
    .logic_reset(logic_reset),
    .in         (tb_in),
    .mode       (mode),
    .out        (out),
    .lamp       (lamp),
    .result     (result)
`ifdef GATE_FIRE_COUNT_EN
    ,
    .fire_count (fire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] in_v;
    logic [2:0] mode_v;
    logic [1:0] exp_lamp;
    logic       exp_result;
    logic [1:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] i, logic [2:0] m,
                              logic [1:0] l, logic res, logic [1:0] o);
    vec_t v;
    v.rst = r; v.in_v = i; v.mode_v = m;
    v.exp_lamp = l; v.exp_result = res; v.exp_out = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    logic_reset = 1'b1;
    tb_in = 2'b00;
    mode  = 3'd4;

    // Expected lamp/result/out after the clock edge each row is applied on.
    vecs.push_back(mk(1, 2'b11, 3'd4, 2'b00, 0, 2'b00)); // in discarded during reset
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b00, 1, 2'b00)); // PRIME loads NOR=1, no pulse
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b00, 1, 2'b00));
    vecs.push_back(mk(0, 2'b01, 3'd0, 2'b01, 0, 2'b11)); // mode->AND on lamp 00 fires
    vecs.push_back(mk(0, 2'b10, 3'd0, 2'b11, 0, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd0, 2'b11, 1, 2'b11)); // AND sees 11
    vecs.push_back(mk(0, 2'b00, 3'd0, 2'b11, 1, 2'b00));
    vecs.push_back(mk(0, 2'b11, 3'd0, 2'b00, 1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd0, 2'b00, 0, 2'b11));
    vecs.push_back(mk(0, 2'b11, 3'd2, 2'b11, 0, 2'b00)); // XOR, simultaneous toggles
    vecs.push_back(mk(0, 2'b00, 3'd2, 2'b11, 0, 2'b00)); // N=2 -> XOR 0, no pulse
    vecs.push_back(mk(0, 2'b10, 3'd2, 2'b01, 0, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd1, 2'b01, 1, 2'b11)); // OR on 01
    vecs.push_back(mk(0, 2'b00, 3'd1, 2'b01, 1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b01, 0, 2'b11)); // mode change OR->NOR
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b01, 0, 2'b00));
    vecs.push_back(mk(0, 2'b01, 3'd6, 2'b00, 0, 2'b00)); // reserved holds
    vecs.push_back(mk(0, 2'b00, 3'd7, 2'b00, 0, 2'b00)); // reserved holds despite NOR=1
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b00, 1, 2'b11));
    vecs.push_back(mk(0, 2'b01, 3'd4, 2'b01, 1, 2'b00));
    vecs.push_back(mk(0, 2'b01, 3'd4, 2'b00, 0, 2'b11)); // back-to-back pulses
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b00, 1, 2'b11));
    vecs.push_back(mk(0, 2'b00, 3'd4, 2'b00, 1, 2'b00));
    vecs.push_back(mk(0, 2'b01, 3'd1, 2'b01, 0, 2'b11));
    vecs.push_back(mk(0, 2'b00, 3'd1, 2'b01, 1, 2'b11));
    vecs.push_back(mk(0, 2'b10, 3'd1, 2'b11, 1, 2'b00)); // net-zero double toggle, OR stays 1
    vecs.push_back(mk(0, 2'b10, 3'd1, 2'b01, 1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd1, 2'b01, 1, 2'b00));
    vecs.push_back(mk(0, 2'b10, 3'd3, 2'b11, 1, 2'b00)); // NAND on 01 = 1
    vecs.push_back(mk(0, 2'b00, 3'd3, 2'b11, 0, 2'b11)); // NAND on 11 = 0
    vecs.push_back(mk(0, 2'b00, 3'd5, 2'b11, 1, 2'b11)); // XNOR N=2 = 1
    vecs.push_back(mk(0, 2'b01, 3'd5, 2'b10, 1, 2'b00));
    vecs.push_back(mk(0, 2'b00, 3'd5, 2'b10, 0, 2'b11)); // XNOR N=1 = 0

    #1;
    check("reset_lamp", 32'(lamp), 32'h0);
    check("reset_result", 32'(result), 32'h0);
    check("reset_out", 32'(out), 32'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      logic_reset = vecs[k].rst;
      tb_in = vecs[k].in_v;
      mode  = vecs[k].mode_v;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lamp", k), 32'(lamp), 32'(vecs[k].exp_lamp));
      check($sformatf("vec%0d_result", k), 32'(result), 32'(vecs[k].exp_result));
      check($sformatf("vec%0d_out", k), 32'(out), 32'(vecs[k].exp_out));
    end

    // Reset asserted in the middle of an out pulse: lamp 10, result 0, OR -> fires.
    @(negedge clk);
    tb_in = 2'b00;
    mode  = 3'd1;
    @(posedge clk);
    #1;
    check("pulse_before_reset", 32'(out), 32'h3);
    #2;
    logic_reset = 1'b1;
    #1;
    check("midpulse_rst_out", 32'(out), 32'h0);
    check("midpulse_rst_lamp", 32'(lamp), 32'h0);
    check("midpulse_rst_result", 32'(result), 32'h0);
    @(negedge clk);
    logic_reset = 1'b0;
    mode = 3'd4;
    @(posedge clk);
    #1;
    check("prime_out", 32'(out), 32'h0);
    check("prime_result", 32'(result), 32'h1);
    @(posedge clk);
    #1;
    check("run_after_prime_out", 32'(out), 32'h0);

`ifdef GATE_FIRE_COUNT_EN
    @(negedge clk);
    logic_reset = 1'b1;
    #1;
    check("fc_reset", 32'(fire_count), 32'h0);
    @(negedge clk);
    logic_reset = 1'b0;
    mode = 3'd4;
    tb_in = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("fc_idle", 32'(fire_count), 32'h0);
    tb_in = 2'b01;
    @(posedge clk);
    #1;
    check("fc_first_toggle", 32'(fire_count), 32'h0);
    @(posedge clk);
    #1;
    check("fc_first_pulse", 32'(fire_count), 32'h1);
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
    end
    #1;
    check("fc_saturated", 32'(fire_count), 32'hFFFF);
    tb_in = 2'b00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
